// File: rtl/song_player_if.sv
// song_player_if: control, song-memory and keycode signals between the player and its surroundings
interface song_player_if #(parameter int ADDR_W = 8);
  logic              start;
  logic              stop;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic [7:0]        keycode;
  logic              busy;
  logic              song_done;
  logic              enc_err;
  modport master(input start, stop, rom_data, output rom_addr, keycode, busy, song_done, enc_err);
  modport slave(output start, stop, rom_data, input rom_addr, keycode, busy, song_done, enc_err);
endinterface

// File: rtl/song_player.sv
// song_player: walks a song memory and plays each note event as a keyboard keycode
module song_player #(
  parameter int TICK_DIV  = 1_000_000,
  parameter int GAP_TICKS = 1,
  parameter int ADDR_W    = 8
) (
  input logic         clk,
  input logic         reset,
  song_player_if.master bus
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, PLAY, GAP, DONE} state_t;
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [TW-1:0]     r_tick;
  logic [7:0]        r_dur, r_key, w_key;
  logic              r_err, w_ok, w_wrap, w_last, w_go, w_count;
  // index is {octave, note, flat}; result is {valid, keycode}
  function automatic logic [8:0] encode(input logic [6:0] k);
    case (k)
      7'h12: return 9'h11d;  7'h14: return 9'h11b;  7'h16: return 9'h106;  7'h18: return 9'h119;
      7'h1a: return 9'h105;  7'h1c: return 9'h111;  7'h1e: return 9'h110;
      7'h22: return 9'h136;  7'h24: return 9'h137;  7'h26: return 9'h138;  7'h28: return 9'h114;
      7'h2a: return 9'h11a;  7'h2c: return 9'h108;  7'h2e: return 9'h115;
      7'h32: return 9'h117;  7'h34: return 9'h11c;  7'h36: return 9'h118;  7'h38: return 9'h11e;
      7'h3a: return 9'h112;  7'h3c: return 9'h113;  7'h3e: return 9'h12f;  7'h42: return 9'h130;
      7'h15: return 9'h122;  7'h17: return 9'h107;  7'h1d: return 9'h104;
      7'h27: return 9'h151;  7'h2b: return 9'h131;  7'h2d: return 9'h132;  7'h2f: return 9'h133;
      7'h35: return 9'h135;  7'h3d: return 9'h139;  7'h3f: return 9'h145;
      default: return 9'h000;
    endcase
  endfunction
  assign {w_ok, w_key} = bus.rom_data[11:9] == 3'd0 ? 9'h100 : encode(bus.rom_data[14:8]);
  assign w_count = r_state == PLAY || r_state == GAP;
  assign w_wrap  = w_count && r_tick == TW'(TICK_DIV - 1);
  assign w_last  = w_wrap && r_dur == 8'd1;
  assign w_go    = bus.start && !bus.stop;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_go ? FETCH : IDLE;
      FETCH:   w_next = WAIT;
      WAIT:    w_next = bus.rom_data[15] ? DONE : PLAY;
      PLAY:    w_next = w_last ? (GAP_TICKS == 0 ? FETCH : GAP) : PLAY;
      GAP:     w_next = w_last ? FETCH : GAP;
      default: w_next = IDLE;
    endcase
    if (bus.stop && r_state != IDLE) w_next = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_tick  <= '0;
      r_dur   <= '0;
      r_key   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_addr  <= w_next == IDLE ? '0 : (w_next == FETCH && r_state != IDLE) ? r_addr + 1'b1 : r_addr;
      r_tick  <= w_count && !w_wrap && w_next != IDLE ? r_tick + 1'b1 : '0;
      r_dur   <= w_next == IDLE ? 8'd0 :
                 r_state == WAIT ? (bus.rom_data[7:0] == 8'd0 ? 8'd1 : bus.rom_data[7:0]) :
                 w_wrap ? (w_last ? 8'(GAP_TICKS) : r_dur - 8'd1) : r_dur;
      r_key   <= r_state == WAIT && w_next == PLAY ? w_key : r_key;
      r_err   <= r_state == IDLE && w_go ? 1'b0 : (r_state == WAIT && w_next == PLAY && !w_ok) ? 1'b1 : r_err;
    end
  end
  assign bus.rom_addr  = r_addr;
  assign bus.keycode   = r_state == PLAY ? r_key : 8'h00;
  assign bus.busy      = r_state != IDLE;
  assign bus.song_done = r_state == DONE;
  assign bus.enc_err   = r_err;
endmodule

// File: tb/tb_song_player.sv
// tb_song_player: randomized and directed checks of song_player against a timeline model
module tb_song_player;
  localparam int T = 4, G = 1, AW = 2;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  song_player_if #(.ADDR_W(AW)) bus();
  song_player #(.TICK_DIV(T), .GAP_TICKS(G), .ADDR_W(AW)) dut(.clk(clk), .reset(reset), .bus(bus));
  logic [15:0] rom [4];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];
  int checks = 0, errors = 0;
  typedef struct {logic [7:0] key; bit busy, done, err, chk_addr, last; logic [AW-1:0] addr;} exp_t;
  exp_t q[$];
  exp_t cur;
  bit m_busy, m_err;
  logic [AW-1:0] m_addr;
  localparam logic [7:0] NAT [22] = '{8'h1d, 8'h1b, 8'h06, 8'h19, 8'h05, 8'h11, 8'h10,
                                      8'h36, 8'h37, 8'h38, 8'h14, 8'h1a, 8'h08, 8'h15,
                                      8'h17, 8'h1c, 8'h18, 8'h1e, 8'h12, 8'h13, 8'h2f, 8'h30};
  localparam logic [15:0] FLAT [10] = '{16'h1222, 16'h1307, 16'h1604, 16'h2351, 16'h2531,
                                        16'h2632, 16'h2733, 16'h3235, 16'h3639, 16'h3745};
  function automatic logic [8:0] ref_key(input logic [2:0] o, input logic [2:0] n, input logic f);
    int oi = int'(o), ni = int'(n);
    logic [15:0] e;
    if (ni == 0) return 9'h100;
    if (!f && oi >= 1 && oi <= 3) return {1'b1, NAT[(oi - 1) * 7 + ni - 1]};
    if (!f && oi == 4 && ni == 1) return {1'b1, NAT[21]};
    if (f) for (int i = 0; i < 10; i++) begin
      e = FLAT[i];
      if (int'(e[15:12]) == oi && int'(e[11:8]) == ni) return {1'b1, e[7:0]};
    end
    return 9'h000;
  endfunction
  function automatic exp_t mk(logic [7:0] k, bit b, bit d, bit e, bit c, bit l, logic [AW-1:0] a);
    exp_t x;
    x.key = k; x.busy = b; x.done = d; x.err = e; x.chk_addr = c; x.last = l; x.addr = a;
    return x;
  endfunction
  function automatic logic [15:0] word(int o, int n, int f, int d);
    logic [15:0] w;
    w = {1'b0, 3'(o), 3'(n), 1'(f), 8'(d)};
    return w;
  endfunction
  task automatic expand();
    logic [15:0] w = rom[m_addr];
    logic [8:0] r;
    int d;
    q.push_back(mk(8'h00, 1, 0, m_err, 1, 0, m_addr));
    q.push_back(mk(8'h00, 1, 0, m_err, 0, 0, m_addr));
    if (w[15]) q.push_back(mk(8'h00, 1, 1, m_err, 0, 1, m_addr));
    else begin
      r = ref_key(w[14:12], w[11:9], w[8]);
      if (!r[8]) m_err = 1;
      d = w[7:0] == 8'd0 ? 1 : int'(w[7:0]);
      repeat (d * T) q.push_back(mk(r[7:0], 1, 0, m_err, 0, 0, m_addr));
      repeat (G * T) q.push_back(mk(8'h00, 1, 0, m_err, 0, 0, m_addr));
      m_addr = m_addr + 1'b1;
    end
  endtask
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_busy = 0; m_err = 0; q.delete();
      cur = mk(8'h00, 0, 0, 0, 1, 0, '0);
    end else if (!m_busy) begin
      if (bus.start && !bus.stop) begin
        m_busy = 1; m_err = 0; m_addr = '0; q.delete();
        expand();
        cur = q.pop_front();
      end else cur = mk(8'h00, 0, 0, m_err, 1, 0, '0);
    end else if (bus.stop || cur.last) begin
      m_busy = 0; m_err = cur.err; q.delete();
      cur = mk(8'h00, 0, 0, m_err, 1, 0, '0);
    end else begin
      if (q.size() == 0) expand();
      cur = q.pop_front();
    end
  end
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      check("model_keycode", 32'(bus.keycode), 32'(cur.key));
      check("model_busy", 32'(bus.busy), 32'(cur.busy));
      check("model_done", 32'(bus.song_done), 32'(cur.done));
      check("model_err", 32'(bus.enc_err), 32'(cur.err));
      if (cur.chk_addr) check("model_addr", 32'(bus.rom_addr), 32'(cur.addr));
    end
  end
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    bus.start = 1; tick(1); bus.start = 0;
  endtask
  task automatic idle_outputs(string name);
    check({name, "_key"}, 32'(bus.keycode), 32'h00);
    check({name, "_busy"}, 32'(bus.busy), 32'h0);
    check({name, "_done"}, 32'(bus.song_done), 32'h0);
    check({name, "_addr"}, 32'(bus.rom_addr), 32'h0);
  endtask
  initial begin
    bus.start = 0; bus.stop = 0;
    for (int i = 0; i < 4; i++) rom[i] = 16'h8000;
    tick(2);
    idle_outputs("reset");
    check("reset_err", 32'(bus.enc_err), 32'h0);
    reset = 0;
    tick(1);
    rom[0] = word(1, 1, 0, 2); rom[1] = 16'h8000;
    pulse_start();
    check("t1_fetch_addr", 32'(bus.rom_addr), 32'h0);
    check("t1_fetch_busy", 32'(bus.busy), 32'h1);
    tick(2);  check("t1_key_c3", 32'(bus.keycode), 32'h1d);
    tick(7);  check("t1_key_c10", 32'(bus.keycode), 32'h1d);
    tick(1);  check("t1_gap_c11", 32'(bus.keycode), 32'h00);
    tick(6);  check("t1_done_c17", 32'(bus.song_done), 32'h1);
    tick(1);  check("t1_idle_c18", 32'(bus.busy), 32'h0);
    rom[0] = word(2, 7, 1, 1); rom[1] = word(0, 0, 0, 1); rom[2] = word(3, 3, 0, 1); rom[3] = 16'h8000;
    pulse_start();
    tick(2);  check("t2_bb2", 32'(bus.keycode), 32'h33);
    tick(10); check("t2_rest_key", 32'(bus.keycode), 32'h00);
    check("t2_rest_busy", 32'(bus.busy), 32'h1);
    tick(10); check("t2_e3", 32'(bus.keycode), 32'h18);
    tick(11); check("t2_idle", 32'(bus.busy), 32'h0);
    check("t2_err", 32'(bus.enc_err), 32'h0);
    rom[0] = word(1, 5, 1, 1); rom[1] = 16'h8000;
    pulse_start();
    tick(2);  check("t3_key", 32'(bus.keycode), 32'h00);
    check("t3_err", 32'(bus.enc_err), 32'h1);
    tick(20); check("t3_err_sticky", 32'(bus.enc_err), 32'h1);
    rom[0] = word(1, 1, 0, 2);
    pulse_start();
    check("t4_err_cleared", 32'(bus.enc_err), 32'h0);
    tick(4);
    bus.stop = 1; tick(1); bus.stop = 0;
    idle_outputs("t4_stop");
    pulse_start();
    check("t4_restart_addr", 32'(bus.rom_addr), 32'h0);
    tick(20);
    bus.start = 1; bus.stop = 1; tick(1); bus.start = 0; bus.stop = 0;
    check("t5_start_stop", 32'(bus.busy), 32'h0);
    pulse_start();
    tick(4);
    reset = 1; #1;
    idle_outputs("t6_reset");
    check("t6_reset_err", 32'(bus.enc_err), 32'h0);
    #1 reset = 0;
    tick(1);
    for (int i = 0; i < 4; i++) rom[i] = word(1, 1, 0, 1);
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      check("t7_wrap_addr", 32'(bus.rom_addr), 32'(i % 4));
      check("t7_wrap_busy", 32'(bus.busy), 32'h1);
      tick(10);
    end
    bus.stop = 1; tick(1); bus.stop = 0;
    repeat (10) begin
      for (int i = 0; i < 4; i++) begin
        rom[i] = 16'($urandom);
        rom[i][15] = $urandom_range(0, 3) == 0;
        rom[i][7:0] = 8'($urandom_range(0, 3));
      end
      pulse_start();
      for (int c = 0; c < 150; c++) begin
        bus.start = $urandom_range(0, 15) == 0;
        bus.stop = $urandom_range(0, 99) == 0;
        tick(1);
      end
      bus.start = 0; bus.stop = 1; tick(1); bus.stop = 0;
      tick(2);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
